mem_write_buffer: RTL and testbench

- Posted-write FIFO between the data cache/controller and the memory bus.
- Accepts word writes (30-bit word address, 32-bit data, 4-bit byte enables) from the CPU side in a single cycle.
- Drains them in order to memory through a memen/memdone handshake, decoupling the CPU from memory write latency.
- Store-to-memory ordering is preserved strictly first-in first-out.

---
 rtl/mem_write_buffer.sv | 105 ++++++++++
 tb/tb_mem_write_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_buffer.sv
// Posted-write FIFO between cache/controller and memory bus; optional WB_MERGE_EN enables write coalescing.
// Latency: a write accepted on edge N is presented on memen/memadr from cycle N+1; no empty bypass.
// Backpressure: done drops when all DEPTH entries are occupied; the CPU holds its request until done.
module mem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     adr,
  input  logic [DW-1:0]     data,
  input  logic [DW/8-1:0]   byteen,
  input  logic              en,
  output logic              done,
  output logic [AW-1:0]     memadr,
  output logic [DW-1:0]     memdata,
  output logic [DW/8-1:0]   membyteen,
  output logic              memen,
  input  logic              memdone
);

  localparam int BW = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  // Entry storage; contents are don't-care after reset, only pointers are cleared.
  logic [AW-1:0] mem_adr  [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [BW-1:0] mem_be   [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic full;
  logic push;
  logic pop;

  // Fullness is judged on the current count only: a pop this cycle does not free a slot for this cycle's push.
  assign full  = (count == CNT_FULL);
  assign memen = (count != '0);
  assign pop   = memen && memdone;

`ifdef WB_MERGE_EN
  logic [PW-1:0] last;
  logic          merge;

  // Coalesce only into the newest entry, and only when it is not also the head
  // (count >= 2), because the head is already visible on the memory bus.
  assign last  = tail - PTR_ONE;
  assign merge = en && reset && (count >= CW'(2)) && (adr == mem_adr[last]);
  assign push  = en && reset && !full && !merge;
  assign done  = push || merge;
`else
  assign push  = en && reset && !full;
  assign done  = push;
`endif

  // Head entry drives the bus; zeros when nothing is pending.
  always_comb begin
    memadr    = '0;
    memdata   = '0;
    membyteen = '0;
    if (memen) begin
      memadr    = mem_adr[head];
      memdata   = mem_data[head];
      membyteen = mem_be[head];
    end
  end

  // Pointer and occupancy bookkeeping; reset discards any pending writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Entry writes: new entries at the tail, merged byte lanes into the newest entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr[tail]  <= adr;
      mem_data[tail] <= data;
      mem_be[tail]   <= byteen;
    end
`ifdef WB_MERGE_EN
    else if (merge) begin
      for (int i = 0; i < BW; i++) begin
        if (byteen[i]) mem_data[last][8*i +: 8] <= data[8*i +: 8];
      end
      mem_be[last] <= mem_be[last] | byteen;
    end
`endif
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboard bench for mem_write_buffer: directed writes push expected entries, a monitor checks every pop.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Memory-side stalls are produced by holding memdone low.
module tb_mem_write_buffer;

  logic        clk;
  logic        reset;
  logic [29:0] adr;
  logic [31:0] data;
  logic [3:0]  byteen;
  logic        en;
  logic        done;
  logic [29:0] memadr;
  logic [31:0] memdata;
  logic [3:0]  membyteen;
  logic        memen;
  logic        memdone;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Without coalescing every write may target adr 0; with it, distinct addresses avoid merging.
`ifdef WB_MERGE_EN
  localparam int ADR_STEP = 1;
`else
  localparam int ADR_STEP = 0;
`endif

  mem_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .data      (data),
    .byteen    (byteen),
    .en        (en),
    .done      (done),
    .memadr    (memadr),
    .memdata   (memdata),
    .membyteen (membyteen),
    .memen     (memen),
    .memdone   (memdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Single-cycle write attempt; the expected entry is queued from the bench's own expectation.
  task automatic write_expect(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b,
                              input logic exp_done, input string name);
    en = 1'b1; adr = a; data = d; byteen = b;
    @(negedge clk);
    check(name, done, exp_done);
    if (exp_done) sb.push_back('{a: a, d: d, b: b});
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Drain with memdone high, counting cycles memen stays up.
  task automatic drain(input int exp_cycles, input string name);
    int n;
    n = 0;
    memdone = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (memen !== 1'b1) break;
      n++;
    end
    check(name, n, exp_cycles);
    @(posedge clk); #1;
  endtask

  // Monitor: every pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && memen === 1'b1 && memdone === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got adr %0h data %0h expected no pending write", memadr, memdata);
      end else begin
        mon_e = sb.pop_front();
        check("pop_adr",    memadr,    mon_e.a);
        check("pop_data",   memdata,   mon_e.d);
        check("pop_byteen", membyteen, mon_e.b);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b1; adr = '0; data = 32'h12345678; byteen = 4'hF; memdone = 1'b0;

    // Reset: request is refused while reset is low.
    @(negedge clk);
    check("done_in_reset", done, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; en = 1'b0;
    @(negedge clk);
    check("rst_memen",     memen,     1'b0);
    check("rst_memadr",    memadr,    30'h0);
    check("rst_memdata",   memdata,   32'h0);
    check("rst_membyteen", membyteen, 4'h0);
    check("rst_done",      done,      1'b0);
    @(posedge clk); #1;

    // memdone on an empty buffer is ignored.
    memdone = 1'b1;
    @(negedge clk);
    check("empty_memen", memen, 1'b0);
    @(posedge clk); #1;

    // Single write with memdone held high.
    write_expect(30'h0, 32'hDEADBEEF, 4'b0001, 1'b1, "single_done");
    @(negedge clk);
    check("single_memen",     memen,     1'b1);
    check("single_memadr",    memadr,    30'h0);
    check("single_memdata",   memdata,   32'hDEADBEEF);
    check("single_membyteen", membyteen, 4'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_empty_memen",   memen,   1'b0);
    check("single_empty_memdata", memdata, 32'h0);
    @(posedge clk); #1;

    // Fill to DEPTH with memdone low, then a fifth write is refused.
    memdone = 1'b0;
    write_expect(30'(0 * ADR_STEP), 32'hAAAAAAAA, 4'hF, 1'b1, "fill0_done");
    write_expect(30'(1 * ADR_STEP), 32'hBBBBBBBB, 4'hF, 1'b1, "fill1_done");
    write_expect(30'(2 * ADR_STEP), 32'hCCCCCCCC, 4'hF, 1'b1, "fill2_done");
    write_expect(30'(3 * ADR_STEP), 32'hDDDDDDDD, 4'hF, 1'b1, "fill3_done");
    en = 1'b1; adr = 30'(4 * ADR_STEP); data = 32'h00000000; byteen = 4'hF;
    @(negedge clk);
    check("full_done",    done,    1'b0);
    check("full_memen",   memen,   1'b1);
    check("full_memdata", memdata, 32'hAAAAAAAA);
    @(posedge clk); #1;
    @(negedge clk);
    check("full_done_hold",    done,    1'b0);
    check("full_memdata_hold", memdata, 32'hAAAAAAAA);
    @(posedge clk); #1;
    // Pop in the same cycle does not free a slot for this cycle's push.
    memdone = 1'b1;
    @(negedge clk);
    check("full_pop_done", done, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_accept_done", done, 1'b1);
    sb.push_back('{a: 30'(4 * ADR_STEP), d: 32'h00000000, b: 4'hF});
    @(posedge clk); #1;
    en = 1'b0;
    drain(3, "full_drain_cycles");

    // Simultaneous push and pop at count 2.
    memdone = 1'b0;
    write_expect(30'h1, 32'h11111111, 4'hF, 1'b1, "pp_w1_done");
    write_expect(30'h2, 32'h22222222, 4'h3, 1'b1, "pp_w2_done");
    memdone = 1'b1;
    write_expect(30'h3, 32'h33333333, 4'hC, 1'b1, "pp_w3_done");
    memdone = 1'b0;
    @(negedge clk);
    check("pp_head_adr",  memadr,  30'h2);
    check("pp_head_data", memdata, 32'h22222222);
    @(posedge clk); #1;
    drain(2, "pp_count_cycles");

    // Same-address write to the newest entry while two are pending.
    memdone = 1'b0;
    write_expect(30'h5, 32'h11111111, 4'hF,    1'b1, "mg_w1_done");
    write_expect(30'h9, 32'h22222222, 4'b0001, 1'b1, "mg_w2_done");
`ifdef WB_MERGE_EN
    en = 1'b1; adr = 30'h9; data = 32'h0000AB00; byteen = 4'b0010;
    @(negedge clk);
    check("mg_merge_done", done, 1'b1);
    sb[sb.size()-1] = '{a: 30'h9, d: 32'h2222AB22, b: 4'b0011};
    @(posedge clk); #1;
    en = 1'b0;
    drain(2, "mg_count_cycles");
`else
    write_expect(30'h9, 32'h0000AB00, 4'b0010, 1'b1, "mg_w3_done");
    drain(3, "mg_count_cycles");
`endif

    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
